// File: rtl/axo32_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads and
// buffers fetched words in a 2-entry FIFO presented to decode as {inst, inst_pc}.
module axo32_fetch #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redir,
  input  logic [31:0] redir_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DROP = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic [2:0]      state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] word_q [DEPTH];
  logic [XLEN-1:0] addr_q [DEPTH];
  logic [CW-1:0]   count, count_nxt, count_after_pop;
  logic            fault, fault_nxt;
  logic            pop, push, flush, req_pc_load;

  // A redirect flushes the FIFO and pre-empts any same-cycle pop or push.
  assign flush           = redir & (state != S_HALT);
  assign pop             = inst_valid & inst_ready & ~redir;
  assign count_after_pop = count - CW'(pop);

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    fault_nxt   = fault;
    push        = 1'b0;
    req_pc_load = 1'b0;
    case (state)
      S_IDLE: if (count_after_pop < CW'(DEPTH)) state_nxt = S_REQ;
      S_REQ: begin
        if (mem_gnt) begin
          pc_nxt      = pc + XLEN'(4);
          req_pc_load = 1'b1;
          state_nxt   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          push      = 1'b1;
          state_nxt = (count_after_pop + CW'(1) < CW'(DEPTH)) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: if (mem_rvalid) state_nxt = S_REQ;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase

    // Redirect overrides everything; an accepted-but-unanswered request must be drained in DROP.
    if (flush) begin
      push = 1'b0;
      if (redir_pc[1:0] != 2'b00) begin
        fault_nxt = 1'b1;
        state_nxt = S_HALT;
      end else begin
        pc_nxt = redir_pc;
        case (state)
          S_IDLE:  state_nxt = S_REQ;
          S_REQ:   state_nxt = mem_gnt ? S_DROP : S_REQ;
          S_WAIT:  state_nxt = mem_rvalid ? S_REQ : S_DROP;
          S_DROP:  state_nxt = mem_rvalid ? S_REQ : S_DROP;
          default: state_nxt = S_IDLE;
        endcase
      end
    end

    count_nxt = flush ? CW'(0) : count_after_pop + CW'(push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_VEC;
      req_pc <= '0;
      count  <= '0;
      fault  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      count <= count_nxt;
      fault <= fault_nxt;
      if (req_pc_load) req_pc <= pc;
    end
  end

  // Shift FIFO: slot 0 is the head; slots beyond count are kept zero so outputs read 0 when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        word_q[0] <= word_q[1];
        addr_q[0] <= addr_q[1];
        word_q[1] <= '0;
        addr_q[1] <= '0;
      end
      if (push) begin
        word_q[count_after_pop[0]] <= mem_rdata;
        addr_q[count_after_pop[0]] <= req_pc;
      end
    end
  end

  assign mem_req     = (state == S_REQ);
  assign mem_addr    = pc;
  assign inst_valid  = (count != CW'(0));
  assign inst        = word_q[0];
  assign inst_pc     = addr_q[0];
  assign fetch_fault = fault;

endmodule
